// File: rtl/i_deser_word_pkg.sv
// Shared definitions for the word deserializer and the matching serializer.
package i_deser_word_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } deser_state_e;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/i_deser_word.sv
// Serial-to-parallel deserializer, MSB first, with bitslip word alignment and
// a registered one-cycle DATA_VALID strobe per emitted word.
module i_deser_word
  import i_deser_word_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             D,
  input  logic             E,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] Q,
  output logic             DATA_VALID
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("i_deser_word: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LK_LAST  = LW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic [LW-1:0]    lk;
  deser_state_e     state;
  logic             word_done;

  assign sr_nxt    = {sr[WIDTH-2:0], D};
  assign word_done = (cnt == CNT_LAST);

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      sr         <= '0;
      cnt        <= '0;
      lk         <= '0;
      state      <= FILL;
      Q          <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (E) begin
        sr <= sr_nxt;
        case (state)
          FILL: begin
            if (word_done) begin
              Q          <= sr_nxt;
              DATA_VALID <= 1'b1;
              cnt        <= '0;
              state      <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            // A slip bit enters sr but not cnt, pushing the boundary out one bit.
            if (BITSLIP) begin
              lk    <= '0;
              state <= LOCK;
            end else if (word_done) begin
              Q          <= sr_nxt;
              DATA_VALID <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LOCK: begin
            if (word_done) begin
              Q          <= sr_nxt;
              DATA_VALID <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (lk == LK_LAST) state <= RUN;
            else               lk    <= lk + 1'b1;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

`ifdef I_DESER_WORD_TIMING_CHECKS
  specify
    (posedge C *> Q)          = 0;
    (posedge C => DATA_VALID) = 0;
    (negedge R *> Q)          = 0;
    (negedge R => DATA_VALID) = 0;
    $setuphold(posedge C &&& R, D,       0, 0);
    $setuphold(posedge C &&& R, E,       0, 0);
    $setuphold(posedge C &&& R, BITSLIP, 0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_i_deser_word.sv
// Bench for i_deser_word: directed scenarios plus random traffic, all checked
// against a bit-history reference model of word framing and slip lockout.
module tb_i_deser_word;
  localparam int W = 4;

  logic         C = 1'b0;
  logic         R = 1'b0;
  logic         D = 1'b0;
  logic         E = 1'b0;
  logic         BS = 1'b0;
  logic [W-1:0] Q;
  logic         DV;

  int n_chk = 0;
  int n_err = 0;

  always #5 C = ~C;

  i_deser_word #(.WIDTH(W)) dut (
    .C(C), .R(R), .D(D), .E(E), .BITSLIP(BS), .Q(Q), .DATA_VALID(DV)
  );

  // Model: last W accepted bits give Q; a word closes once it has collected
  // W bits, or W+1 if a slip landed in it.
  bit           hist[$];
  int           wlen, target, since_slip;
  bit           filled;
  logic [W-1:0] exp_q;
  logic         exp_dv;
  int           cyc = 0, last_dv = -1, last_gap = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    wlen = 0; target = W; since_slip = 2 * W; filled = 1'b0;
    exp_q = '0; exp_dv = 1'b0;
  endtask

  task automatic model_edge(input logic d, input logic e, input logic bs);
    exp_dv = 1'b0;
    if (!e) return;
    hist.push_back(d);
    hist.delete(0);
    wlen++;
    if (filled && bs && since_slip >= 2 * W) begin
      target++;
      since_slip = 0;
    end else begin
      since_slip++;
    end
    if (wlen == target) begin
      for (int i = 0; i < W; i++) exp_q[W-1-i] = hist[i];
      exp_dv = 1'b1; wlen = 0; target = W; filled = 1'b1;
    end
  endtask

  task automatic step(input logic d, input logic e, input logic bs);
    D = d; E = e; BS = bs;
    @(posedge C);
    model_edge(d, e, bs);
    #1;
    chk("q", Q, exp_q);
    chk("dv", DV, exp_dv);
    if (DV === 1'b1) begin
      if (last_dv >= 0) last_gap = cyc - last_dv;
      last_dv = cyc;
    end
    cyc++;
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 R = 1'b0;
    model_reset();
    #1;
    chk("rst_q", Q, 0);
    chk("rst_dv", DV, 0);
    last_dv = -1;
    @(negedge C);
    R = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    model_reset();

    // Basic word 1011 and hold.
    do_reset();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    chk("s1_q", Q, 4'b1011);
    chk("s1_dv", DV, 1);
    step(0, 0, 0); step(1, 0, 0);
    chk("s1_hold", Q, 4'b1011);

    // Enable gap of 3 cycles after bit 2.
    do_reset();
    step(1, 1, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0);
    chk("s2_early", DV, 0);
    step(1, 1, 0);
    chk("s2_q", Q, 4'b1011);
    chk("s2_dv", DV, 1);

    // Words read 1000 from a repeating 0001 stream; one slip realigns them.
    do_reset();
    pat = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      step(pat[3 - ((i + 3) % 4)], 1, (i == 8) || (i == 12) || (i == 17));
      if (i == 7)  chk("s3_misal", Q, 4'b1000);
      if (i == 12) chk("s3_align", Q, 4'b0001);
      if (i == 16) chk("s3_locked", Q, 4'b0001);
      if (i == 20) chk("s3_noemit", DV, 0);
      if (i == 21) chk("s3_reslip", Q, 4'b0010);
    end

    // Slip on the word-completing bit.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i[0], 1, i == 7);
      if (i == 7) chk("s4_nodv", DV, 0);
    end
    chk("s4_dv", DV, 1);
    chk("s4_gap", last_gap, 5);

    // BITSLIP held during FILL is ignored.
    do_reset();
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
    chk("s5_early", DV, 0);
    step(0, 1, 1);
    chk("s5_dv", DV, 1);
    chk("s5_q", Q, 4'b1110);

    // Reset mid-word discards the partial word.
    do_reset();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 1, 0); step(1, 1, 0);
    do_reset();
    step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
    chk("s6_early", DV, 0);
    step(0, 1, 0);
    chk("s6_q", Q, 4'b1100);
    chk("s6_dv", DV, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 80,
                $urandom_range(0, 99) < 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
